// File: rtl/hazard_scoreboard_id_pkg.sv
// Shared pipeline types for the ID-stage hazard scoreboard: register index,
// per-slot destination record and the constants that describe an empty slot.
package hazard_scoreboard_id_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     wr;
    logic     ld;
    reg_idx_t rd;
  } slot_t;

  localparam reg_idx_t REG_ZERO   = '0;
  localparam slot_t    SLOT_EMPTY = '{wr: 1'b0, ld: 1'b0, rd: '0};

  // r0 is hard-wired, so a write to it never produces anything to forward
  function automatic slot_t make_slot(logic reg_write, logic mem_read, reg_idx_t rd);
    return '{wr: reg_write && (rd != REG_ZERO), ld: mem_read, rd: rd};
  endfunction

endpackage

// File: rtl/hazard_scoreboard_id_if.sv
// ID-stage side of the scoreboard: decoded operand info in, stall/bubble and
// registered forwarding destinations out.
interface hazard_scoreboard_id_if #(
  parameter int CNT_W = 16
);
  import hazard_scoreboard_id_pkg::*;

  logic             enable;
  logic             id_valid;
  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  reg_idx_t         id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic             bubble;
  reg_idx_t         ex_m_rd;
  logic             ex_m_reg_write;
  reg_idx_t         m_rd;
  logic             m_reg_write;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_rd, id_reg_write, id_mem_read, flush,
    input  stall, bubble, ex_m_rd, ex_m_reg_write, m_rd, m_reg_write, stall_cycles
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_rd, id_reg_write, id_mem_read, flush,
    output stall, bubble, ex_m_rd, ex_m_reg_write, m_rd, m_reg_write, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_id_hazard_match.sv
// Compares one counted ID source against one in-flight slot; NEED_LD restricts
// the hit to slots holding a load.
module hazard_match
  import hazard_scoreboard_id_pkg::*;
#(
  parameter bit NEED_LD = 1'b0
) (
  input  logic     i_src_counted,
  input  reg_idx_t i_src,
  input  slot_t    i_slot,
  output logic     o_hit
);

  assign o_hit = i_src_counted && i_slot.wr && (i_slot.ld || !NEED_LD) &&
                 (i_slot.rd == i_src);

endmodule

// File: rtl/hazard_scoreboard_id.sv
// Tracks in-flight destinations through EX/MEM/WB, drives the forwarding
// destination registers and requests stalls for hazards forwarding cannot cover.
module hazard_scoreboard_id
  import hazard_scoreboard_id_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_scoreboard_id_if.slave bus
);

  slot_t            r_ex;
  slot_t            r_mem;
  logic             r_wb_wr;
  reg_idx_t         r_wb_rd;
  logic [CNT_W-1:0] r_cnt;

  logic w_rs_counted, w_rt_counted;
  logic w_ex_rs_hit, w_ex_rt_hit, w_mem_rs_hit, w_mem_rt_hit;
  logic w_ex_hit, w_mem_ld_hit, w_load_use, w_stall, w_bubble;

  assign w_rs_counted = bus.id_valid && bus.id_uses_rs && (bus.id_rs != REG_ZERO);
  assign w_rt_counted = bus.id_valid && bus.id_uses_rt && (bus.id_rt != REG_ZERO);

  hazard_match #(.NEED_LD(1'b0)) u_ex_rs (
    .i_src_counted(w_rs_counted), .i_src(bus.id_rs), .i_slot(r_ex), .o_hit(w_ex_rs_hit)
  );
  hazard_match #(.NEED_LD(1'b0)) u_ex_rt (
    .i_src_counted(w_rt_counted), .i_src(bus.id_rt), .i_slot(r_ex), .o_hit(w_ex_rt_hit)
  );
  hazard_match #(.NEED_LD(1'b1)) u_mem_rs (
    .i_src_counted(w_rs_counted), .i_src(bus.id_rs), .i_slot(r_mem), .o_hit(w_mem_rs_hit)
  );
  hazard_match #(.NEED_LD(1'b1)) u_mem_rt (
    .i_src_counted(w_rt_counted), .i_src(bus.id_rt), .i_slot(r_mem), .o_hit(w_mem_rt_hit)
  );

  assign w_ex_hit     = w_ex_rs_hit || w_ex_rt_hit;
  assign w_mem_ld_hit = w_mem_rs_hit || w_mem_rt_hit;
  assign w_load_use   = w_ex_hit && r_ex.ld;

  // Branches resolve in ID, so even an ALU result one ahead is too late for them
  assign w_stall  = bus.id_valid &&
                    (w_load_use || (bus.id_is_branch && (w_ex_hit || w_mem_ld_hit)));
  assign w_bubble = w_stall || bus.flush || !bus.id_valid;

  // NOTE: all state below uses non-blocking assignments so the EX->MEM->WB
  // shift reads the pre-edge values of every slot, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex    <= SLOT_EMPTY;
      r_mem   <= SLOT_EMPTY;
      r_wb_wr <= 1'b0;
      r_wb_rd <= REG_ZERO;
      r_cnt   <= '0;
    end else if (bus.enable) begin
      r_ex    <= w_bubble ? SLOT_EMPTY
                          : make_slot(bus.id_reg_write, bus.id_mem_read, bus.id_rd);
      r_mem   <= r_ex;
      r_wb_wr <= r_mem.wr;
      r_wb_rd <= r_mem.rd;
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.stall          = w_stall;
  assign bus.bubble         = w_bubble;
  assign bus.ex_m_rd        = r_mem.rd;
  assign bus.ex_m_reg_write = r_mem.wr;
  assign bus.m_rd           = r_wb_rd;
  assign bus.m_reg_write    = r_wb_wr;
  assign bus.stall_cycles   = r_cnt;

endmodule

// File: doc/hazard_scoreboard_id.md
# hazard_scoreboard_id

Producer side of the ID-stage forwarding path. The block tracks every in-flight destination register through the EX, MEM and WB slots and drives the registered EX/MEM and MEM/WB destination/write-enable pairs that the ID forwarding logic consumes. It also detects operand hazards that forwarding cannot cover (load-use, and branch-in-ID operands not yet produced) and raises stall/bubble requests to the IF/ID and ID/EX registers. It sits beside the ID stage and is clocked with the pipeline.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  pipeline advance; 0 freezes all state (debug halt).
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W each  ID source registers.
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction actually reads that source.
- `id_is_branch`  in  1  branch/jump-register resolved in ID (needs operands in ID).
- `id_rd`  in  REG_W  ID destination register (already muxed rt/rd/31).
- `id_reg_write`  in  1  ID instruction writes the register file.
- `id_mem_read`  in  1  ID instruction is a load.
- `flush`  in  1  kill the ID instruction (taken branch redirect).
- `stall`  out  1  hold PC and IF/ID (combinational).
- `bubble`  out  1  a NOP is inserted into ID/EX this cycle (combinational).
- `ex_m_rd`  out  REG_W  destination of the instruction in MEM (registered).
- `ex_m_reg_write`  out  1  that instruction writes (registered).
- `m_rd`  out  REG_W  destination of the instruction in WB (registered).
- `m_reg_write`  out  1  that instruction writes (registered).
- `stall_cycles`  out  CNT_W  saturating count of stall cycles since reset.

## Operation
- Three slots EX, MEM, WB, each holding {wr, ld, rd}. `wr` is stored as `id_reg_write && id_rd != 0`, so r0 never forwards and never causes a hazard.
- A source counts when `id_valid`, its `id_uses_*` is set, and it is nonzero.
- Hazard conditions (stall = OR of these, gated by `id_valid`):
  - Load-use: the EX slot has wr&ld and its rd equals a counted source.
  - Branch/ALU: `id_is_branch` and the EX slot has wr with a matching rd.
  - Branch/load: `id_is_branch` and the MEM slot has wr&ld with a matching rd.
- `bubble = stall | flush | !id_valid`.
- Slot update when `enable`=1: WB<=MEM, MEM<=EX, EX<=bubble ? empty : {id_reg_write&&rd!=0, id_mem_read, id_rd}.
- When `enable`=0: slots and counter hold. `stall` and `bubble` still evaluate combinationally.
- `stall` and `flush` together: flush wins for the slot contents (EX gets empty). `stall` is still reported; the IF/ID hold vs redirect priority is resolved outside this block.
- `stall_cycles` increments on every enabled cycle with `stall`=1 and saturates at all-ones.
- The ex_m_/m_ outputs are direct slot register outputs.

## Timing
- Reset: all slots empty. `ex_m_rd`=0, `ex_m_reg_write`=0, `m_rd`=0, `m_reg_write`=0, `stall_cycles`=0. With `id_valid`=0, `stall`=0 and `bubble`=1.
- `reset` mid-stall clears the slots in the same edge. `stall` falls in the next cycle unless new hazards appear.
- Load at ID in cycle t, dependent non-branch at ID in t+1: `stall`=1 in t+1 only. In t+2 the consumer issues, and the EX-stage forwarding handles it.
- Branch dependent on an ALU op one ahead: 1 stall cycle. The next cycle `ex_m_rd` matches with `ex_m_reg_write`=1.
- Branch dependent on a load one ahead: 2 stall cycles. In the third cycle `m_rd` matches with `m_reg_write`=1.
- Destination outputs trail ID issue by 2 cycles (`ex_m_*`) and 3 cycles (`m_*`) of enabled clocks.

## Structure
- Shared pipeline package holds: `REG_W`, the slot struct {wr, ld, rd}, `SLOT_EMPTY` constant, and `REG_ZERO`.
- One natural sub-module: `hazard_match`, a combinational comparator of one source against one slot, instantiated per source per checked slot.

## Test plan
- Reset with `id_valid`=0 → all outputs 0 except `bubble`=1. The counter stays 0 over 10 cycles.
- `lw $3`, then `add $4,$3,$5` → `stall`=1 for exactly 1 cycle, `stall_cycles`=1. Two cycles after the add issues, `ex_m_rd`=4.
- `add $2,..`, then `beq $2,$0` → 1 stall. The next cycle shows `ex_m_rd`=2 and `ex_m_reg_write`=1.
- `lw $7`, then `beq $7,$1` → 2 stall cycles. The third cycle shows `m_rd`=7, `m_reg_write`=1, `stall`=0.
- Writer to $0, then a reader of $0 → no stall, and `ex_m_reg_write`=0 when it reaches MEM.
- Load-use stall with `enable`=0 for 3 cycles → `stall` held at 1 and the counter frozen. `flush` with `stall` → the EX slot is empty on the next edge.
